serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/adder_pkg.sv | 6 +
 rtl/serial_adder_ctrl_adder.sv | 10 +
 rtl/serial_adder_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing constants for the serial adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIBBLE_W = 4;
  localparam int NIBBLES_DEF = 4;
endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// FourBitAdder: 4-bit ripple adder; ports a, b, cin in; sum, cout out
module FourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: nibble-serial add/sub; in clk rst_n start sub a b, out busy done s cout ovf
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  s,
  output logic                         cout,
  output logic                         ovf
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  state_t state, state_nxt;
  logic [W-1:0] a_reg, b_reg, a_sh, b_sh;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum;
  logic [IW-1:0] idx;
  logic sub_reg, c, c_out, accept, last;
  always_comb begin
    a_sh = a_reg >> {idx, 2'b00};
    b_sh = b_reg >> {idx, 2'b00};
    a_nib = a_sh[NIBBLE_W-1:0];
    b_nib = b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_reg}};
    accept = start && (state == IDLE || state == DONE);
    last = idx == IW'(NIBBLES - 1);
    state_nxt = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  FourBitAdder u_add (.a(a_nib), .b(b_nib), .cin(c), .sum(sum), .cout(c_out));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      sub_reg <= 1'b0;
      c <= 1'b0;
      idx <= '0;
      s <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      sub_reg <= sub;
      c <= sub;
      idx <= '0;
    end else if (busy) begin
      c <= c_out;
      idx <= idx + 1'b1;
      for (int i = 0; i < NIBBLES; i++)
        if (idx == IW'(i)) s[i*NIBBLE_W +: NIBBLE_W] <= sum;
      if (last) begin
        cout <= c_out;
        ovf <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (sum[NIBBLE_W-1] != a_reg[W-1]);
      end
    end
  end
endmodule
